// File: rtl/seq_alu_pkg.sv
// seq_alu shared types and helpers.
// Opcodes, FSM states and the leading-zero counter.
package seq_alu_pkg;

  // Widest operand clz_count can scan.
  localparam int MAX_W = 256;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_CLO  = 4'd7,
    OP_CLZ  = 4'd8,
    OP_SLL  = 4'd9,
    OP_SRL  = 4'd10,
    OP_SRA  = 4'd11,
    OP_ROTR = 4'd12
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    FIN
  } state_e;

  function automatic logic [15:0] clz_count(
    input logic [MAX_W-1:0] v,
    input int               w
  );
    logic [15:0] n;
    logic        seen;
    n    = '0;
    seen = 1'b0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < w) begin
        if (v[i]) seen = 1'b1;
        else if (!seen) n = n + 16'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu iterative datapath: shift-add multiply and
// restoring divide sharing one 2*WIDTH accumulator.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               divMode,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   operand;
  logic               mode;
  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     remTrial;
  logic [WIDTH:0]     remDiff;
  logic [2*WIDTH-1:0] accNext;

  // MUL: acc = {partial, multiplier}; DIV: acc = {rem, quotient}.
  always_comb begin
    addSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    remTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remDiff  = remTrial - {1'b0, operand};
    accNext  = acc;
    if (mode) begin
      if (remDiff[WIDTH])
        accNext = {remTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        accNext = {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else if (acc[0]) begin
      accNext = {addSum, acc[WIDTH-1:1]};
    end else begin
      accNext = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      operand <= '0;
      mode    <= 1'b0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, divMode ? opA : opB};
      operand <= divMode ? opB : opA;
      mode    <= divMode;
    end else if (step) begin
      acc <= accNext;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu top: start/busy/done ALU with double-width
// registered result and invert/increment post-processing.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             output_inverted,
  input  logic             output_inc,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_high,
  output logic [WIDTH-1:0] res_low,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_e             state;
  state_e             stateNext;
  logic [WIDTH-1:0]   opA;
  logic [WIDTH-1:0]   opB;
  logic [3:0]         op;
  logic               inv;
  logic               inc;
  logic [SHW-1:0]     cnt;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] rawNext;
  logic [2*WIDTH-1:0] post;
  logic               dzPend;
  logic               illPend;
  logic               dzNext;
  logic               illNext;
  logic               accept;
  logic               iterOp;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] sll;
  logic [2*WIDTH-1:0] srl;
  logic [2*WIDTH-1:0] sra;
  logic [2*WIDTH-1:0] rot;

  // Busy covers the done cycle so a start there is ignored.
  assign busy   = (state != IDLE) || done;
  assign accept = start && !busy;
  assign iterOp = (aluop == OP_MUL)
               || ((aluop == OP_DIV) && (b != '0));

  seq_alu_iter #(
    .WIDTH(WIDTH)
  ) uIter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == ITER),
    .divMode(aluop == OP_DIV),
    .opA    (a),
    .opB    (b),
    .acc    (acc)
  );

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = iterOp ? ITER : EXEC;
      EXEC:    stateNext = FIN;
      ITER:    if (cnt == LAST) stateNext = EXEC;
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    sh  = opB[SHW-1:0];
    sum = {1'b0, opA} + {1'b0, opB};
    sll = {{WIDTH{1'b0}}, opA} << sh;
    srl = {opA, {WIDTH{1'b0}}} >> sh;
    sra = $signed({opA, {WIDTH{1'b0}}}) >>> sh;
    rot = {opA, opA} >> sh;
    rawNext = '0;
    dzNext  = 1'b0;
    illNext = 1'b0;
    unique case (op)
      OP_ADD: rawNext = {{(WIDTH-1){1'b0}}, sum};
      OP_SUB: rawNext = {{WIDTH{opA < opB}}, opA - opB};
      OP_MUL: rawNext = acc;
      OP_DIV: begin
        if (opB == '0) begin
          rawNext = {opA, {WIDTH{1'b1}}};
          dzNext  = 1'b1;
        end else begin
          rawNext = acc;
        end
      end
      OP_AND: rawNext = {{WIDTH{1'b0}}, opA & opB};
      OP_OR:  rawNext = {{WIDTH{1'b0}}, opA | opB};
      OP_XOR: rawNext = {{WIDTH{1'b0}}, opA ^ opB};
      OP_CLO: rawNext = {{WIDTH{1'b0}},
                WIDTH'(clz_count(MAX_W'(~opA), WIDTH))};
      OP_CLZ: rawNext = {{WIDTH{1'b0}},
                WIDTH'(clz_count(MAX_W'(opA), WIDTH))};
      OP_SLL: rawNext = sll;
      OP_SRL: rawNext = {srl[WIDTH-1:0], srl[2*WIDTH-1:WIDTH]};
      OP_SRA: rawNext = {sra[WIDTH-1:0], sra[2*WIDTH-1:WIDTH]};
      OP_ROTR: rawNext = {{WIDTH{1'b0}}, rot[WIDTH-1:0]};
      default: illNext = 1'b1;
    endcase
  end

  always_comb begin
    post = inv ? ~raw : raw;
    if (inc) post = post + (2*WIDTH)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      res_high    <= '0;
      res_low     <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      cnt         <= '0;
      opA         <= '0;
      opB         <= '0;
      op          <= '0;
      inv         <= 1'b0;
      inc         <= 1'b0;
      raw         <= '0;
      dzPend      <= 1'b0;
      illPend     <= 1'b0;
    end else begin
      state <= stateNext;
      done  <= (state == FIN);
      if (accept) begin
        opA         <= a;
        opB         <= b;
        op          <= aluop;
        inv         <= output_inverted;
        inc         <= output_inc;
        cnt         <= '0;
        div_by_zero <= 1'b0;
        illegal_op  <= 1'b0;
      end
      if (state == ITER) cnt <= cnt + SHW'(1);
      if (state == EXEC) begin
        raw     <= rawNext;
        dzPend  <= dzNext;
        illPend <= illNext;
      end
      if (state == FIN) begin
        {res_high, res_low} <= post;
        div_by_zero         <= dzPend;
        illegal_op          <= illPend;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32.
// One task per scenario, hand-computed expectations.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        output_inverted;
  logic        output_inc;
  logic        busy;
  logic        done;
  logic [31:0] res_high;
  logic [31:0] res_low;
  logic        div_by_zero;
  logic        illegal_op;

  int tests = 0;
  int fails = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .aluop          (aluop),
    .a              (a),
    .b              (b),
    .output_inverted(output_inverted),
    .output_inc     (output_inc),
    .busy           (busy),
    .done           (done),
    .res_high       (res_high),
    .res_low        (res_low),
    .div_by_zero    (div_by_zero),
    .illegal_op     (illegal_op)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // lat = rising edges after the accepting edge until done is seen.
  task automatic runOp(
    input  logic [3:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        inv,
    input  logic        inc,
    input  bit          poke,
    output int          lat
  );
    for (int i = 0; i < 4 && busy; i++) begin
      @(posedge clk); #1;
    end
    aluop = op; a = x; b = y;
    output_inverted = inv; output_inc = inc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 5) begin
        start = 1'b1; aluop = 4'd0;
        a = 32'h1; b = 32'h1; output_inverted = 1'b1;
      end
      if (poke && lat == 6) begin
        start = 1'b0; output_inverted = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL reset_done: got %b want 0", done);
    end
    tests++;
    if ({res_high, res_low} !== 64'h0) begin
      fails++;
      $display("FAIL reset_res: got %h%h want 0", res_high, res_low);
    end
    tests++;
    if ({div_by_zero, illegal_op} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags: got %b%b want 00",
               div_by_zero, illegal_op);
    end
  endtask

  task automatic test_add_negate;
    int lat;
    runOp(4'd0, 32'd5, 32'd3, 1'b1, 1'b1, 1'b0, lat);
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL add_latency: got %0d want 2", lat);
    end
    tests++;
    if ({res_high, res_low} !== 64'hFFFFFFFF_FFFFFFF8) begin
      fails++;
      $display("FAIL add_neg: got %h_%h want FFFFFFFF_FFFFFFF8",
               res_high, res_low);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL add_single_pulse: done=%b busy=%b want 0 0",
               done, busy);
    end
  endtask

  task automatic test_sub_clz;
    int lat;
    runOp(4'd1, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'hFFFFFFFF_FFFFFFFE) begin
      fails++;
      $display("FAIL sub: got %h_%h want FFFFFFFF_FFFFFFFE",
               res_high, res_low);
    end
    runOp(4'd8, 32'h0000FFFF, 32'h0, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if (res_low !== 32'd16 || res_high !== 32'd0) begin
      fails++;
      $display("FAIL clz: got %h_%h want 0_16", res_high, res_low);
    end
    runOp(4'd7, 32'hFFF00000, 32'h0, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if (res_low !== 32'd12 || res_high !== 32'd0) begin
      fails++;
      $display("FAIL clo: got %h_%h want 0_12", res_high, res_low);
    end
  endtask

  task automatic test_mul;
    int lat;
    runOp(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, lat);
    tests++;
    if (lat !== 34) begin
      fails++; $display("FAIL mul_latency: got %0d want 34", lat);
    end
    tests++;
    if ({res_high, res_low} !== 64'hFFFFFFFE_00000001) begin
      fails++;
      $display("FAIL mul: got %h_%h want FFFFFFFE_00000001",
               res_high, res_low);
    end
  endtask

  task automatic test_div;
    int lat;
    runOp(4'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 34) begin
      fails++; $display("FAIL div_latency: got %0d want 34", lat);
    end
    tests++;
    if (res_low !== 32'd14 || res_high !== 32'd2
        || div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL div: got q=%0d r=%0d dz=%b want 14 2 0",
               res_low, res_high, div_by_zero);
    end
    runOp(4'd3, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL div0_latency: got %0d want 2", lat);
    end
    tests++;
    if (res_low !== 32'hFFFFFFFF || res_high !== 32'd9
        || div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL div0: got %h_%h dz=%b want 9_FFFFFFFF 1",
               res_high, res_low, div_by_zero);
    end
  endtask

  task automatic test_shift;
    int lat;
    runOp(4'd10, 32'hF000000F, 32'd4, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'hF0000000_0F000000) begin
      fails++;
      $display("FAIL srl: got %h_%h want F0000000_0F000000",
               res_high, res_low);
    end
    tests++;
    if (div_by_zero !== 1'b0) begin
      fails++;
      $display("FAIL dz_clear: got %b want 0", div_by_zero);
    end
    runOp(4'd12, 32'hF000000F, 32'd4, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'h00000000_FF000000) begin
      fails++;
      $display("FAIL rotr: got %h_%h want 0_FF000000",
               res_high, res_low);
    end
    runOp(4'd11, 32'hF000000F, 32'd4, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'hF0000000_FF000000) begin
      fails++;
      $display("FAIL sra: got %h_%h want F0000000_FF000000",
               res_high, res_low);
    end
    runOp(4'd9, 32'hF000000F, 32'd36, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'h0000000F_000000F0) begin
      fails++;
      $display("FAIL sll_upper_b: got %h_%h want F_000000F0",
               res_high, res_low);
    end
    runOp(4'd10, 32'hF000000F, 32'd32, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'h00000000_F000000F) begin
      fails++;
      $display("FAIL srl_sh0: got %h_%h want 0_F000000F",
               res_high, res_low);
    end
  endtask

  task automatic test_illegal;
    int lat;
    runOp(4'd14, 32'h1234, 32'h5678, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'h0 || illegal_op !== 1'b1) begin
      fails++;
      $display("FAIL illegal14: got %h_%h ill=%b want 0 1",
               res_high, res_low, illegal_op);
    end
    runOp(4'd13, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b0, lat);
    repeat (5) begin @(posedge clk); #1; end
    tests++;
    if ({res_high, res_low} !== 64'hFFFFFFFF_FFFFFFFF
        || illegal_op !== 1'b1) begin
      fails++;
      $display("FAIL illegal13_hold: got %h_%h ill=%b want all-ones 1",
               res_high, res_low, illegal_op);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    runOp(4'd6, 32'h0F0F0F0F, 32'hFF00FF00, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if ({res_high, res_low} !== 64'h00000000_F00FF00F) begin
      fails++;
      $display("FAIL xor: got %h_%h want 0_F00FF00F",
               res_high, res_low);
    end
    aluop = 4'd0; a = 32'd1; b = 32'd1;
    output_inverted = 1'b0; output_inc = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ignored: busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== 2 || res_low !== 32'd2) begin
      fails++;
      $display("FAIL b2b_result: lat=%0d L=%h want 2 2", lat, res_low);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    for (int i = 0; i < 4 && busy; i++) begin
      @(posedge clk); #1;
    end
    aluop = 4'd2; a = 32'd3; b = 32'd5;
    output_inverted = 1'b0; output_inc = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0
        || {res_high, res_low} !== 64'h0) begin
      fails++;
      $display("FAIL midreset: busy=%b done=%b res=%h_%h want 0 0 0",
               busy, done, res_high, res_low);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL midreset_nodone: got done want none");
    end
    runOp(4'd0, 32'd7, 32'd8, 1'b0, 1'b0, 1'b0, lat);
    tests++;
    if (lat !== 2 || {res_high, res_low} !== 64'd15) begin
      fails++;
      $display("FAIL post_reset_add: lat=%0d res=%h_%h want 2 0_F",
               lat, res_high, res_low);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; aluop = '0;
    a = '0; b = '0;
    output_inverted = 1'b0; output_inc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_add_negate;
    test_sub_clz;
    test_mul;
    test_div;
    test_shift;
    test_illegal;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshake-driven ALU with double-width result. It is the next-generation replacement for the fixed 32-bit ALU top level. All operand, opcode and post-processing inputs are captured on a single `start` strobe. Iterative multiply and divide are sequenced by one internal FSM, and every result is registered. A single registered `done` pulse marks completion for every opcode.

Parameters:
- WIDTH, 32, operand and result-half width; must be ≥4 and a power of two.
- SHW, $clog2(WIDTH), derived shift-amount width; not overridable.

Ports:
- clk, in, 1, system clock; all state updates on its rising edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, request; sampled only while busy=0.
- aluop, in, 4, operation select (encoding in Behaviour).
- a, in, WIDTH, operand A (dividend, shift source).
- b, in, WIDTH, operand B (divisor; b[SHW-1:0] is the shift amount).
- output_inverted, in, 1, post-op: bitwise invert the 2*WIDTH result.
- output_inc, in, 1, post-op: add 1 to the 2*WIDTH result, after inversion.
- busy, out, 1, operation in flight.
- done, out, 1, one-cycle completion pulse.
- res_high, out, WIDTH, upper result half.
- res_low, out, WIDTH, lower result half.
- div_by_zero, out, 1, set with done for a DIV with b=0; cleared on next accepted start.
- illegal_op, out, 1, set with done for aluop 13–15; cleared on next accepted start.

Behaviour:
- Reset: synchronous, active-high.
  - Effect: FSM to IDLE; busy, done, div_by_zero and illegal_op = 0; res_high and res_low = 0; iteration counter = 0.
  - Mid-operation: any in-flight mul/div is abandoned; no done pulse is issued.
- Opcode encoding: {H = res_high, L = res_low}; all arithmetic is unsigned.
  - 0 ADD: L = a+b; H = {0, carry}.
  - 1 SUB: L = a−b; H = all-ones if a<b, else 0.
  - 2 MUL: {H,L} = a*b.
  - 3 DIV: L = quotient, H = remainder.
  - 4 AND, 5 OR, 6 XOR: L = a op b; H = 0.
  - 7 CLO: L = count of leading ones in a; H = 0.
  - 8 CLZ: L = count of leading zeros in a; H = 0.
  - 9 SLL: {H,L} = {0,a} << sh.
  - 10 SRL: L = a >> sh; H = bits shifted out, left-justified.
  - 11 SRA: as SRL, but L is arithmetic-shifted.
  - 12 ROTR: L = a rotated right by sh; H = 0.
  - 13–15: {H,L} = 0 and illegal_op = 1.
- Handshake:
  - start with busy=0 at edge k: all inputs latched; busy=1 after edge k.
  - start while busy=1: ignored; inputs are not re-latched.
- FSM states:
  - IDLE: on start, go to EXEC for a single-cycle op, or ITER for MUL/DIV.
  - EXEC: one cycle; result registered.
  - ITER: WIDTH cycles, counter counts 0..WIDTH−1.
    - MUL: shift-add, one multiplier bit per cycle.
    - DIV: restoring, one quotient bit per cycle.
  - FIN: post-processing applied; res_high/res_low loaded; done=1; returns to IDLE.
- Latency (start edge k to outputs valid and done=1):
  - Single-cycle ops: done=1 in the cycle after edge k+2.
  - MUL/DIV: done=1 in the cycle after edge k+WIDTH+2.
  - busy: 1 from edge k through the done cycle; busy deasserts together with done.
  - Back-to-back: start may be asserted in the done cycle. It is ignored there and accepted on the next cycle when busy=0.
- Divide by zero (DIV with b=0): no iteration; goes EXEC→FIN. L = all-ones, H = a, div_by_zero = 1.
- Post-processing:
  - Applied to the full 2*WIDTH value, for every opcode including illegal ones.
  - Inversion first, then +1 with carry from L into H; wraps modulo 2^(2*WIDTH).
  - Both flags set = two's-complement negate.
- Shift amount: sh = b[SHW-1:0]; upper b bits are ignored. sh=0 gives L = a and H = 0 (SRA: H = 0).
- Output hold: res_high, res_low and the flags hold their values between done pulses.

Decomposition:
- Package seq_alu_pkg:
  - aluop_e enum (ADD..ROTR, 4 bits).
  - state_e enum (IDLE, EXEC, ITER, FIN).
  - Function clz_count(WIDTH). CLO is computed as clz_count(~a).
- Sub-module seq_alu_iter: shared mul/div datapath with a 2*WIDTH accumulator and mode select. It is stepped by the parent FSM's counter.
- Shifter, rotate, logic and add/sub logic stay inline.

Test Plan (WIDTH=32):
- ADD, a=5, b=3, output_inverted=1, output_inc=1 → after 2 cycles {H,L} = FFFFFFFF_FFFFFFF8 and done pulses once.
- SUB, a=3, b=5 → L=FFFFFFFE, H=FFFFFFFF. Then CLZ with a=0000FFFF → L=16, H=0.
- MUL, a=b=FFFFFFFF → done exactly 34 cycles after the start edge; H=FFFFFFFE, L=00000001. A start pulse mid-operation is ignored.
- DIV, a=100, b=7 → L=14, H=2 at 34 cycles. DIV, a=9, b=0 → L=FFFFFFFF, H=9, div_by_zero=1 at 2 cycles.
- SRL, a=F000000F, b=4 → L=0F000000, H=F0000000. ROTR, same inputs → L=FF000000. aluop=14 → zeros with illegal_op=1.
- rst asserted at ITER cycle 10 of a MUL → next cycle busy=0, done=0, outputs=0. A new ADD then completes normally.
